// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage with an in-order prefetch queue over a request/grant/response
// memory port; redirects flush the queue and drop stale in-flight responses.
module fetch_prefetch #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] pc_out4
);

  localparam int unsigned           PW      = $clog2(QUEUE_DEPTH);
  localparam logic [PW+1:0]         DEPTH_L = (PW+2)'(QUEUE_DEPTH);
  localparam logic [DATA_WIDTH-1:0] FOUR    = DATA_WIDTH'(4);

  typedef logic [PW:0] ptr_t;

  ptr_t                  alloc_q, alloc_d, fill_q, fill_d, head_q, head_d, drop_q, drop_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] pc_mem_q    [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [QUEUE_DEPTH];

  ptr_t        occ, inflight;
  logic [PW+1:0] used;
  logic        grant, fill_en, pop;
  logic        unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign occ      = alloc_q - head_q;
  assign inflight = alloc_q - fill_q;
  // Entries still owed a stale response count against capacity, so nothing is overwritten.
  assign used     = {1'b0, occ} + {1'b0, drop_q};

  assign imem_req    = !rst && !redirect && (used < DEPTH_L);
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;
  assign fill_en     = imem_rvalid && !redirect && (drop_q == '0);
  assign instr_valid = !rst && !redirect && (fill_q != head_q);
  assign pop         = instr_valid && instr_ready;

  assign instr   = instr_mem_q[head_q[PW-1:0]];
  assign pc_out  = pc_mem_q[head_q[PW-1:0]];
  assign pc_out4 = pc_out + FOUR;

  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      drop_d     = drop_q + inflight - ptr_t'(imem_rvalid);
      fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else begin
      if (grant) begin
        alloc_d    = alloc_q + ptr_t'(1);
        fetch_pc_d = fetch_pc_q + FOUR;
      end
      if (imem_rvalid) begin
        if (drop_q != '0) drop_d = drop_q - ptr_t'(1);
        else              fill_d = fill_q + ptr_t'(1);
      end
      if (pop) head_d = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      if (grant)   pc_mem_q[alloc_q[PW-1:0]]   <= fetch_pc_q;
      if (fill_en) instr_mem_q[fill_q[PW-1:0]] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: fixed-latency memory model returning ~addr,
// a per-cycle vector table plus sequences for stall, redirect, grant hold and async reset.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_out4;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  logic        rv [4];
  logic [31:0] ra [4];

  always #5 clk = ~clk;

  fetch_prefetch #(.DATA_WIDTH(32), .RESET_PC(32'h100), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc_out(pc_out), .pc_out4(pc_out4)
  );

  // Fixed-latency in-order memory; granted in cycle N, data in cycle N+lat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        rv[k] <= 1'b0;
        ra[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        rv[k] <= rv[k+1];
        ra[k] <= ra[k+1];
      end
      rv[3] <= 1'b0;
      if (imem_req && imem_gnt) begin
        rv[lat-1] <= 1'b1;
        ra[lat-1] <= imem_addr;
      end
    end
  end

  assign imem_rvalid = rv[0];
  assign imem_rdata  = ~ra[0];

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0.
  task automatic do_reset(input int l);
    rst = 1'b1;
    redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1; instr_ready = 1'b1;
    lat = l;
    next_cycle();
    next_cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc_out4, 32'h4);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic chk_instr(input string name, input logic [31:0] exp_pc);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_pc"}, pc_out, exp_pc);
    chk({name, "_instr"}, instr, ~exp_pc);
    chk({name, "_pc4"}, pc_out4, exp_pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rd   rpc           gnt   rdy   req   addr          vld   pc
    vecs[0]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h100,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h104,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h108,  1'b1, 32'h100};
    vecs[3]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h10C,  1'b1, 32'h104};
    vecs[4]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h110,  1'b1, 32'h108};
    vecs[5]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h114,  1'b1, 32'h10C};
    vecs[6]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h118,  1'b1, 32'h110};
    vecs[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h11C,  1'b1, 32'h114};
    vecs[8]  = '{1'b1, 32'h2003, 1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h2004, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h2008, 1'b1, 32'h2000};

    // Streaming from RESET_PC with 1-cycle memory, then redirect to an unaligned target.
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      redirect = vecs[i].rd; redirect_pc = vecs[i].rpc;
      imem_gnt = vecs[i].gnt; instr_ready = vecs[i].rdy;
      #3;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
      if (vecs[i].vld) chk_instr($sformatf("v%0d", i), vecs[i].pc);
      next_cycle();
    end
    redirect = 1'b0;

    // Decode stall for 10 cycles: queue fills to 4 then request drops; release drains in order.
    do_reset(1);
    for (int k = 0; k < 20; k++) begin
      instr_ready = (k >= 10);
      #3;
      if (k < 10) begin
        chk($sformatf("stall%0d_req", k), 32'(imem_req), 32'(k < 4));
        if (k >= 2) chk_instr($sformatf("stall%0d", k), 32'h100);
      end else begin
        chk_instr($sformatf("drain%0d", k), 32'h100 + 32'(4 * (k - 10)));
      end
      next_cycle();
    end

    // 3-cycle memory, redirect with two requests in flight: both responses dropped.
    do_reset(3);
    for (int k = 0; k < 9; k++) begin
      redirect = (k == 2); redirect_pc = 32'h2000;
      #3;
      if (k == 2) chk("rd3_req", 32'(imem_req), 32'd0);
      if (k == 3) chk("rd3_addr", imem_addr, 32'h2000);
      if (k == 3) chk("rd3_req_after", 32'(imem_req), 32'd1);
      if (k < 7) chk($sformatf("rd3_c%0d_valid", k), 32'(instr_valid), 32'd0);
      if (k == 7) chk_instr("rd3_first", 32'h2000);
      if (k == 8) chk_instr("rd3_second", 32'h2004);
      next_cycle();
    end
    redirect = 1'b0;

    // Grant withheld for 5 cycles: request and address held.
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      imem_gnt = (k >= 5);
      #3;
      if (k <= 5) begin
        chk($sformatf("hold%0d_req", k), 32'(imem_req), 32'd1);
        chk($sformatf("hold%0d_addr", k), imem_addr, 32'h100);
      end
      if (k == 6) chk("hold6_addr", imem_addr, 32'h104);
      if (k < 7) chk($sformatf("hold%0d_valid", k), 32'(instr_valid), 32'd0);
      if (k == 7) chk_instr("hold7", 32'h100);
      next_cycle();
    end

    // Asynchronous reset mid-stream.
    do_reset(1);
    repeat (5) next_cycle();
    #1;
    chk("pre_async_valid", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_instr", instr, 32'h0);
    chk("async_pc4", pc_out4, 32'h4);
    next_cycle();
    rst = 1'b0;
    #3;
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h100);
    chk("restart_valid", 32'(instr_valid), 32'd0);
    next_cycle();
    next_cycle();
    #3;
    chk_instr("restart_first", 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch stage with an in-order prefetch queue. It replaces the single-cycle, combinational-memory fetch path with a request/grant/response interface to instruction memory, so memory latency can vary. It also adds decode backpressure and redirect flushing that discards stale in-flight responses. It sits between the PC-redirect logic (branch/jump resolution) and decode.

## Interface
- `DATA_WIDTH`, 32: instruction and address width.
- `RESET_PC`, 0: first fetch address after reset; low two bits must be 0.
- `QUEUE_DEPTH`, 4: queue entries and maximum outstanding requests; power of 2, ≥2; ≥4 sustains 1 instr/cycle with 1-cycle memory.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  taken branch/jump this cycle; flush and refetch.
- `redirect_pc`  in  DATA_WIDTH  redirect target; bits [1:0] ignored (treated as 00).
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  DATA_WIDTH  fetch address; word aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; responses in request order.
- `imem_rdata`  in  DATA_WIDTH  instruction word.
- `instr_valid`  out  1  head entry holds a filled instruction.
- `instr_ready`  in  1  decode accepts this cycle.
- `instr`  out  DATA_WIDTH  instruction at head.
- `pc_out`  out  DATA_WIDTH  PC of that instruction.
- `pc_out4`  out  DATA_WIDTH  `pc_out` + 4, modulo 2^DATA_WIDTH.

## Operation
- State: `fetch_pc`; queue of QUEUE_DEPTH entries {pc, instr}; pointers `alloc`, `fill`, `head` (each log2(QUEUE_DEPTH)+1 bits, wrap naturally); `drop_cnt` (log2(QUEUE_DEPTH)+1 bits).
- Occupancy = `alloc` − `head`; in-flight = `alloc` − `fill`.
- `imem_req` = !`redirect` && (occupancy + `drop_cnt`) < QUEUE_DEPTH. It is combinational. `imem_addr` = `fetch_pc`.
- Grant (`imem_req` && `imem_gnt`):
  - write `fetch_pc` into entry[`alloc`].pc;
  - `alloc`+1;
  - `fetch_pc` += 4, wrapping at 2^DATA_WIDTH.
- Response (`imem_rvalid`):
  - if `drop_cnt` > 0: discard the data and decrement `drop_cnt`;
  - else: write `imem_rdata` into entry[`fill`].instr and increment `fill`.
- `instr_valid` = (`fill` != `head`) && !`redirect`. Outputs come from entry[`head`].
- Pop when `instr_valid` && `instr_ready`: `head`+1.
- Redirect cycle:
  - no grant, since `imem_req` = 0;
  - no pop, since `instr_valid` = 0;
  - any `imem_rvalid` that cycle is discarded;
  - `drop_cnt` ← `drop_cnt` + in-flight − (`imem_rvalid` && `drop_cnt`==0 ? 1 : 0) − (`imem_rvalid` && `drop_cnt`>0 ? 1 : 0), which simplifies to `drop_cnt` + in-flight − `imem_rvalid`;
  - `alloc`, `fill`, `head` ← 0;
  - `fetch_pc` ← {`redirect_pc`[DATA_WIDTH-1:2], 2'b00}.
- Back-to-back redirects accumulate into `drop_cnt`. Only the last target survives.
- A held request (`imem_req`=1, `imem_gnt`=0) keeps `imem_addr` stable unless `redirect` asserts.
- Full: occupancy + `drop_cnt` == QUEUE_DEPTH forces `imem_req`=0. No entry is ever overwritten.
- Empty: `instr_valid`=0. `instr`, `pc_out`, and `pc_out4` are don't-care.

## Timing
- Reset, asynchronous: `fetch_pc`=RESET_PC; pointers and `drop_cnt`=0; queue storage=0.
- During reset: `imem_req`=0, `instr_valid`=0, `instr`=0, `pc_out`=0, `pc_out4`=4.
- Memory must also reset; responses pending at reset are never presented afterwards.
- Cycle 0 is the first cycle after `rst` falls. In it, `imem_req`=1 with `imem_addr`=RESET_PC.
- Latency: data returned in cycle N appears at `instr_valid` in cycle N+1. There is no bypass.
- With 1-cycle memory (grant in cycle 0, rvalid in cycle 1), the first `instr_valid` is in cycle 2. After that it delivers 1 instr/cycle while `instr_ready`=1.
- Redirect penalty: the request to `redirect_pc` issues the cycle after `redirect`. The first new instruction is valid after memory latency + 1 cycle.
- `redirect` has priority over grant, response fill, and pop in the same cycle.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory, `instr_ready`=1 -> addresses 0x100, 0x104, …; `instr_valid` from cycle 2; `pc_out`=0x100 then 0x104 consecutively; `pc_out4`=0x104 on the first instruction.
- `instr_ready`=0 for 10 cycles, QUEUE_DEPTH=4 -> `imem_req` drops once 4 entries are allocated. On release, all instructions are delivered in order with no gaps or duplicates.
- 3-cycle memory, `redirect` with `redirect_pc`=0x2000 while 2 requests are in flight -> 2 stale responses are dropped; the next delivered `pc_out`=0x2000 with its correct `instr`.
- `redirect_pc`=0x2003 -> `imem_addr`=0x2000 the next cycle.
- `imem_gnt`=0 for 5 cycles -> `imem_req`=1 and `imem_addr` is unchanged throughout; `fetch_pc` advances only on the grant.
- `rst` asserted mid-stream, asynchronously -> `imem_req`/`instr_valid` go to 0 without a clock edge; after release, fetch restarts at RESET_PC.
